hazard_ctrl_param: RTL and testbench
====================================

Name: hazard_ctrl_param

Overview:
Parametrised pipeline interlock controller for the 5-stage MIPS core. It is the next generation of the ID-stage hazard detector.
- Detects load-use and branch-operand hazards across N source operands.
- Handles data-memory wait freezes.
- Tracks interlock state in an FSM and keeps saturating stall/freeze performance counters plus a stuck-stall watchdog.
- Sits beside the ID stage and drives the PC, IF/ID and ID/EX write/flush controls.

Parameters:
REG_AW, 5, register address width
NUM_SRC, 2, number of ID-stage source operands checked (1..4)
ZERO_REG, 1, 1 = destination address 0 never creates a hazard
CNT_W, 16, width of stall/freeze performance counters
MAX_STALL, 4, consecutive interlock cycles before watchdog error

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID instruction valid
id_src  in  NUM_SRC*REG_AW  source register addresses; operand k at bits [k*REG_AW +: REG_AW]
id_src_used  in  NUM_SRC  per-operand "actually read" flag
id_branch  in  1  ID holds a branch that compares in ID
ex_valid  in  1  EX instruction valid
ex_dst  in  REG_AW  EX destination register
ex_reg_write  in  1  EX writes register file
ex_mem_read  in  1  EX is a load
mem_valid  in  1  MEM instruction valid
mem_dst  in  REG_AW  MEM destination register
mem_mem_read  in  1  MEM is a load
dmem_wait  in  1  data memory not ready, freeze whole pipe
cnt_clr  in  1  synchronous clear of counters and watchdog flag
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID register write enable
idex_flush  out  1  insert bubble into ID/EX
pipe_freeze  out  1  hold all pipeline registers
hz_cause  out  2  00 none, 01 load-use, 10 branch-operand, 11 freeze
stall_cnt  out  CNT_W  interlock cycles, saturating
freeze_cnt  out  CNT_W  freeze cycles, saturating
wd_err  out  1  sticky watchdog error

Behaviour:
- match(d) = any operand k with id_src_used[k] and id_src[k]==d, and not (ZERO_REG and d==0).
- LU = id_valid & ex_valid & ex_mem_read & match(ex_dst).
- BR = id_valid & id_branch & ((ex_valid & ex_reg_write & match(ex_dst)) | (mem_valid & mem_mem_read & match(mem_dst))).
- Hazard decode and outputs are combinational from current inputs, same cycle, zero latency. State, counters and wd_err update on the clock edge.
- Priority, highest first:
  - dmem_wait: pipe_freeze=1, pc_write=0, ifid_write=0, idex_flush=0, hz_cause=11.
  - else LU: pc_write=0, ifid_write=0, idex_flush=1, hz_cause=01.
  - else BR: same controls as LU, hz_cause=10.
  - else: pc_write=1, ifid_write=1, idex_flush=0, pipe_freeze=0, hz_cause=00.
- A branch whose operand is loaded in EX is stalled as LU first. Next cycle the load sits in MEM, so it is stalled as BR, giving 2 bubbles total.
- FSM states:
  - RUN: no hazard this cycle.
  - ILOCK: LU or BR active without freeze.
  - FREEZE: dmem_wait.
  - Next state = the class of the current cycle's condition.
  - ILOCK→FREEZE→ILOCK is legal. Freeze does not reset the ILOCK run length.
- stall_cnt increments each ILOCK cycle; freeze_cnt increments each FREEZE cycle. Both saturate at all-ones; no wrap.
- Run length: an internal counter counts consecutive ILOCK cycles. It is held during FREEZE and cleared on RUN.
- Watchdog: when the run length reaches MAX_STALL, wd_err sets and stays set until cnt_clr or reset.
- cnt_clr: zeroes both counters, the run length and wd_err at the next edge. It has priority over increment in the same cycle. It does not affect the stall outputs.
- Reset (asynchronous, any time including mid-stall):
  - state=RUN; counters, run length and wd_err = 0.
  - While rst_n=0 the outputs are forced to pc_write=1, ifid_write=1, idex_flush=0, pipe_freeze=0, hz_cause=00, regardless of inputs.
- When id_valid=0, no LU or BR is raised, even if the addresses match.

Test Plan:
- Load-use: EX lw $5 (ex_mem_read=1, ex_dst=5); ID add reads src0=5 with used=1 → pc_write=0, ifid_write=0, idex_flush=1, hz_cause=01 that cycle. stall_cnt=1 after the edge.
- Branch chain: ID beq on $3 while EX lw $3; next cycle the load is in MEM with mem_dst=3 → cause 01 then 10, 2 bubbles, stall_cnt=2. A branch with an EX ALU write to $3 and no load → exactly 1 bubble, cause 10.
- $zero and unused operands: ex_dst=0 load with src=0, ZERO_REG=1 → no stall. A match only on an operand with id_src_used=0 → no stall. Repeat with ZERO_REG=0 → stall.
- Freeze priority: dmem_wait=1 together with an LU → pipe_freeze=1, idex_flush=0, cause 11. freeze_cnt increments and stall_cnt does not. When dmem_wait drops, LU resumes with cause 01.
- Watchdog/saturation: hold LU for 4 cycles with MAX_STALL=4 → wd_err=1 and stays 1 after the hazard clears. Run with CNT_W=3 for 10 stall cycles → stall_cnt=7. Pulse cnt_clr → all 0.
- Reset mid-stall: assert rst_n=0 asynchronously during an LU → outputs are immediately the RUN values and counters=0. Release rst_n → stall resumes if LU is still present.

Source files
------------

// File: rtl/hazard_ctrl_param.sv
// ID-stage pipeline interlock controller: load-use and branch-operand hazards over
// NUM_SRC operands, data-memory freeze, saturating perf counters and a stuck-stall watchdog.
module hazard_ctrl_param #(
  parameter int REG_AW    = 5,
  parameter int NUM_SRC   = 2,
  parameter int ZERO_REG  = 1,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic                      id_branch,
  input  logic                      ex_valid,
  input  logic [REG_AW-1:0]         ex_dst,
  input  logic                      ex_reg_write,
  input  logic                      ex_mem_read,
  input  logic                      mem_valid,
  input  logic [REG_AW-1:0]         mem_dst,
  input  logic                      mem_mem_read,
  input  logic                      dmem_wait,
  input  logic                      cnt_clr,
  output logic                      pc_write,
  output logic                      ifid_write,
  output logic                      idex_flush,
  output logic                      pipe_freeze,
  output logic [1:0]                hz_cause,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          freeze_cnt,
  output logic                      wd_err
);

  localparam int RUN_W = $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_ILOCK  = 2'b01,
    ST_FREEZE = 2'b10
  } state_t;

  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_LU     = 2'b01;
  localparam logic [1:0] CAUSE_BR     = 2'b10;
  localparam logic [1:0] CAUSE_FREEZE = 2'b11;

  logic [NUM_SRC-1:0] ex_hit;
  logic [NUM_SRC-1:0] mem_hit;
  logic               ex_dst_ok;
  logic               mem_dst_ok;
  logic               ex_match;
  logic               mem_match;
  logic               lu;
  logic               br;

  state_t             state_reg;
  state_t             cls;
  logic [CNT_W-1:0]   stall_cnt_reg;
  logic [CNT_W-1:0]   freeze_cnt_reg;
  logic [RUN_W-1:0]   run_len_reg;
  logic [RUN_W-1:0]   run_len_next;
  logic               wd_err_reg;

  // Per-operand address compare against the EX and MEM destinations.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_AW-1:0] src;
      assign src         = id_src[gi*REG_AW +: REG_AW];
      assign ex_hit[gi]  = id_src_used[gi] && (src == ex_dst);
      assign mem_hit[gi] = id_src_used[gi] && (src == mem_dst);
    end
  endgenerate

  assign ex_dst_ok  = !((ZERO_REG != 0) && (ex_dst == '0));
  assign mem_dst_ok = !((ZERO_REG != 0) && (mem_dst == '0));
  assign ex_match   = (|ex_hit) && ex_dst_ok;
  assign mem_match  = (|mem_hit) && mem_dst_ok;

  assign lu = id_valid && ex_valid && ex_mem_read && ex_match;
  assign br = id_valid && id_branch &&
              ((ex_valid && ex_reg_write && ex_match) ||
               (mem_valid && mem_mem_read && mem_match));

  always_comb begin
    cls = ST_RUN;
    if (dmem_wait) begin
      cls = ST_FREEZE;
    end else if (lu || br) begin
      cls = ST_ILOCK;
    end
  end

  // Stall controls are zero-latency; reset forces the free-running values.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_flush  = 1'b0;
    pipe_freeze = 1'b0;
    hz_cause    = CAUSE_NONE;
    if (rst_n) begin
      if (dmem_wait) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        pipe_freeze = 1'b1;
        hz_cause    = CAUSE_FREEZE;
      end else if (lu || br) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
        hz_cause   = lu ? CAUSE_LU : CAUSE_BR;
      end
    end
  end

  // Run length restarts on entry from RUN, is held across freezes and saturates.
  always_comb begin
    run_len_next = run_len_reg;
    case (cls)
      ST_ILOCK: begin
        if (state_reg == ST_RUN) begin
          run_len_next = RUN_W'(1);
        end else if (run_len_reg != RUN_MAX) begin
          run_len_next = run_len_reg + RUN_W'(1);
        end
      end
      ST_RUN:  run_len_next = '0;
      default: run_len_next = run_len_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_RUN;
      stall_cnt_reg  <= '0;
      freeze_cnt_reg <= '0;
      run_len_reg    <= '0;
      wd_err_reg     <= 1'b0;
    end else begin
      state_reg <= cls;
      if (cnt_clr) begin
        stall_cnt_reg  <= '0;
        freeze_cnt_reg <= '0;
        run_len_reg    <= '0;
        wd_err_reg     <= 1'b0;
      end else begin
        run_len_reg <= run_len_next;
        if (cls == ST_ILOCK && stall_cnt_reg != '1) begin
          stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
        if (cls == ST_FREEZE && freeze_cnt_reg != '1) begin
          freeze_cnt_reg <= freeze_cnt_reg + CNT_W'(1);
        end
        if (run_len_next == RUN_MAX) begin
          wd_err_reg <= 1'b1;
        end
      end
    end
  end

  assign stall_cnt  = stall_cnt_reg;
  assign freeze_cnt = freeze_cnt_reg;
  assign wd_err     = wd_err_reg;

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// Bench for hazard_ctrl_param: three instances (default, ZERO_REG=0, CNT_W=3) share
// directed stimulus; a rule-level model is compared every cycle plus literal spot checks.
module tb_hazard_ctrl_param;

  localparam int AW = 5;
  localparam int NS = 2;
  localparam int MAXS = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            id_valid, id_branch, ex_valid, ex_reg_write, ex_mem_read;
  logic            mem_valid, mem_mem_read, dmem_wait, cnt_clr;
  logic [NS*AW-1:0] id_src;
  logic [NS-1:0]   id_src_used;
  logic [AW-1:0]   ex_dst, mem_dst;

  logic pw_a, iw_a, fl_a, fr_a, wd_a;
  logic pw_b, iw_b, fl_b, fr_b, wd_b;
  logic pw_c, iw_c, fl_c, fr_c, wd_c;
  logic [1:0]  hc_a, hc_b, hc_c;
  logic [15:0] sc_a, fc_a, sc_b, fc_b;
  logic [2:0]  sc_c, fc_c;

  int  checks = 0;
  int  errors = 0;
  bit  run_cmp = 1'b0;

  int  m_stall  [3];
  int  m_freeze [3];
  int  m_run    [3];
  bit  m_wd     [3];

  always #5 clk = ~clk;

  hazard_ctrl_param #(.REG_AW(AW), .NUM_SRC(NS), .ZERO_REG(1), .CNT_W(16), .MAX_STALL(MAXS)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_branch(id_branch), .ex_valid(ex_valid), .ex_dst(ex_dst), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .mem_valid(mem_valid), .mem_dst(mem_dst), .mem_mem_read(mem_mem_read),
    .dmem_wait(dmem_wait), .cnt_clr(cnt_clr), .pc_write(pw_a), .ifid_write(iw_a), .idex_flush(fl_a),
    .pipe_freeze(fr_a), .hz_cause(hc_a), .stall_cnt(sc_a), .freeze_cnt(fc_a), .wd_err(wd_a));

  hazard_ctrl_param #(.REG_AW(AW), .NUM_SRC(NS), .ZERO_REG(0), .CNT_W(16), .MAX_STALL(MAXS)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_branch(id_branch), .ex_valid(ex_valid), .ex_dst(ex_dst), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .mem_valid(mem_valid), .mem_dst(mem_dst), .mem_mem_read(mem_mem_read),
    .dmem_wait(dmem_wait), .cnt_clr(cnt_clr), .pc_write(pw_b), .ifid_write(iw_b), .idex_flush(fl_b),
    .pipe_freeze(fr_b), .hz_cause(hc_b), .stall_cnt(sc_b), .freeze_cnt(fc_b), .wd_err(wd_b));

  hazard_ctrl_param #(.REG_AW(AW), .NUM_SRC(NS), .ZERO_REG(1), .CNT_W(3), .MAX_STALL(MAXS)) dut_c (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_branch(id_branch), .ex_valid(ex_valid), .ex_dst(ex_dst), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .mem_valid(mem_valid), .mem_dst(mem_dst), .mem_mem_read(mem_mem_read),
    .dmem_wait(dmem_wait), .cnt_clr(cnt_clr), .pc_write(pw_c), .ifid_write(iw_c), .idex_flush(fl_c),
    .pipe_freeze(fr_c), .hz_cause(hc_c), .stall_cnt(sc_c), .freeze_cnt(fc_c), .wd_err(wd_c));

  // ---------------- model ----------------
  function automatic int cnt_max(input int i);
    return (i == 2) ? 7 : 65535;
  endfunction

  function automatic bit reads_reg(input logic [AW-1:0] d, input bit zr);
    if (zr && d == 0) return 1'b0;
    for (int k = 0; k < NS; k++) begin
      if (id_src_used[k] && id_src[k*AW +: AW] == d) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [1:0] exp_cause(input int i);
    bit zr;
    bit lu;
    bit br;
    zr = (i != 1);
    lu = id_valid && ex_valid && ex_mem_read && reads_reg(ex_dst, zr);
    br = id_valid && id_branch &&
         ((ex_valid && ex_reg_write && reads_reg(ex_dst, zr)) ||
          (mem_valid && mem_mem_read && reads_reg(mem_dst, zr)));
    if (!rst_n) return 2'd0;
    if (dmem_wait) return 2'd3;
    if (lu) return 2'd1;
    if (br) return 2'd2;
    return 2'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n || cnt_clr) begin
        m_stall[i]  <= 0;
        m_freeze[i] <= 0;
        m_run[i]    <= 0;
        m_wd[i]     <= 1'b0;
      end else begin
        logic [1:0] c;
        int nr;
        c = exp_cause(i);
        nr = m_run[i];
        if (c == 2'd1 || c == 2'd2) begin
          nr = (m_run[i] + 1 > MAXS) ? MAXS : m_run[i] + 1;
          m_stall[i] <= (m_stall[i] + 1 > cnt_max(i)) ? cnt_max(i) : m_stall[i] + 1;
        end else if (c == 2'd3) begin
          m_freeze[i] <= (m_freeze[i] + 1 > cnt_max(i)) ? cnt_max(i) : m_freeze[i] + 1;
        end else begin
          nr = 0;
        end
        m_run[i] <= nr;
        m_wd[i]  <= m_wd[i] || (nr >= MAXS);
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] t=%0t: got %0h expected %0h", name, inst, $time, act, exp);
    end
  endtask

  task automatic cmp_inst(input int i, input logic pw, input logic iw, input logic fl, input logic fr,
                          input logic [1:0] hc, input logic [15:0] sc, input logic [15:0] fc, input logic wd);
    logic [1:0] c;
    c = exp_cause(i);
    check("hz_cause", i, 32'(hc), 32'(c));
    check("pc_write", i, 32'(pw), 32'(c == 2'd0));
    check("ifid_write", i, 32'(iw), 32'(c == 2'd0));
    check("idex_flush", i, 32'(fl), 32'(c == 2'd1 || c == 2'd2));
    check("pipe_freeze", i, 32'(fr), 32'(c == 2'd3));
    check("stall_cnt", i, 32'(sc), 32'(m_stall[i]));
    check("freeze_cnt", i, 32'(fc), 32'(m_freeze[i]));
    check("wd_err", i, 32'(wd), 32'(m_wd[i]));
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      cmp_inst(0, pw_a, iw_a, fl_a, fr_a, hc_a, sc_a, fc_a, wd_a);
      cmp_inst(1, pw_b, iw_b, fl_b, fr_b, hc_b, sc_b, fc_b, wd_b);
      cmp_inst(2, pw_c, iw_c, fl_c, fr_c, hc_c, {13'd0, sc_c}, {13'd0, fc_c}, wd_c);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    id_valid = 0; id_branch = 0; id_src = '0; id_src_used = '0;
    ex_valid = 0; ex_dst = '0; ex_reg_write = 0; ex_mem_read = 0;
    mem_valid = 0; mem_dst = '0; mem_mem_read = 0;
    dmem_wait = 0; cnt_clr = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_lu5();
    idle();
    id_valid = 1; id_src = {5'd0, 5'd5}; id_src_used = 2'b01;
    ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_dst = 5'd5;
  endtask

  initial begin
    idle();
    run_cmp = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    check("lit_reset_stall", 0, 32'(sc_a), 32'd0);
    check("lit_reset_pc", 0, 32'(pw_a), 32'd1);

    // load-use
    set_lu5(); #1;
    check("lit_lu_pc", 0, 32'(pw_a), 32'd0);
    check("lit_lu_flush", 0, 32'(fl_a), 32'd1);
    check("lit_lu_cause", 0, 32'(hc_a), 32'd1);
    cyc(1);
    check("lit_lu_stall", 0, 32'(sc_a), 32'd1);
    idle(); cyc(1);

    // branch on a loaded register: LU then BR
    id_valid = 1; id_branch = 1; id_src = {5'd0, 5'd3}; id_src_used = 2'b01;
    ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_dst = 5'd3; #1;
    check("lit_brchain_c1", 0, 32'(hc_a), 32'd1);
    cyc(1);
    ex_valid = 0; ex_mem_read = 0; ex_reg_write = 0;
    mem_valid = 1; mem_mem_read = 1; mem_dst = 5'd3; #1;
    check("lit_brchain_c2", 0, 32'(hc_a), 32'd2);
    cyc(1);
    check("lit_brchain_stall", 0, 32'(sc_a), 32'd3);
    idle(); cyc(1);

    // branch on an ALU result in EX, operand 1
    id_valid = 1; id_branch = 1; id_src = {5'd3, 5'd0}; id_src_used = 2'b10;
    ex_valid = 1; ex_reg_write = 1; ex_dst = 5'd3; #1;
    check("lit_bralu_cause", 0, 32'(hc_a), 32'd2);
    cyc(1);
    idle(); #1;
    check("lit_bralu_done", 0, 32'(hc_a), 32'd0);
    cyc(1);

    // $zero destination and unused operand
    id_valid = 1; id_src = {5'd0, 5'd0}; id_src_used = 2'b01;
    ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_dst = 5'd0; #1;
    check("lit_zero_zr1", 0, 32'(hc_a), 32'd0);
    check("lit_zero_zr0", 1, 32'(hc_b), 32'd1);
    cyc(1);
    id_src = {5'd7, 5'd1}; ex_dst = 5'd7; #1;
    check("lit_unused_a", 0, 32'(hc_a), 32'd0);
    check("lit_unused_b", 1, 32'(hc_b), 32'd0);
    cyc(1);
    id_src = {5'd0, 5'd7}; id_valid = 0; #1;
    check("lit_idinvalid", 0, 32'(hc_a), 32'd0);
    cyc(1);
    check("lit_stall_a4", 0, 32'(sc_a), 32'd4);
    check("lit_stall_b5", 1, 32'(sc_b), 32'd5);

    // freeze over a load-use
    set_lu5(); dmem_wait = 1; #1;
    check("lit_frz_freeze", 0, 32'(fr_a), 32'd1);
    check("lit_frz_flush", 0, 32'(fl_a), 32'd0);
    check("lit_frz_cause", 0, 32'(hc_a), 32'd3);
    cyc(2);
    check("lit_frz_fcnt", 0, 32'(fc_a), 32'd2);
    check("lit_frz_scnt", 0, 32'(sc_a), 32'd4);
    dmem_wait = 0; #1;
    check("lit_frz_resume", 0, 32'(hc_a), 32'd1);

    // watchdog: freeze in the middle of a run holds the run length
    cyc(2);
    dmem_wait = 1; cyc(1);
    dmem_wait = 0; cyc(1);
    check("lit_wd_before", 0, 32'(wd_a), 32'd0);
    cyc(1);
    check("lit_wd_set", 0, 32'(wd_a), 32'd1);
    idle(); cyc(1);
    check("lit_wd_sticky", 0, 32'(wd_a), 32'd1);
    set_lu5(); cyc(2);
    check("lit_sat_a", 0, 32'(sc_a), 32'd10);
    check("lit_sat_c", 2, 32'(sc_c), 32'd7);
    check("lit_sat_fc_c", 2, 32'(fc_c), 32'd3);

    // clear wins over increment and leaves the stall outputs alone
    cnt_clr = 1; #1;
    check("lit_clr_cause", 0, 32'(hc_a), 32'd1);
    cyc(1);
    cnt_clr = 0;
    check("lit_clr_stall", 0, 32'(sc_a), 32'd0);
    check("lit_clr_freeze", 0, 32'(fc_a), 32'd0);
    check("lit_clr_wd", 0, 32'(wd_a), 32'd0);

    // asynchronous reset in the middle of a stall
    cyc(2);
    #2;
    rst_n = 1'b0; #1;
    check("lit_rst_pc", 0, 32'(pw_a), 32'd1);
    check("lit_rst_flush", 0, 32'(fl_a), 32'd0);
    check("lit_rst_cause", 0, 32'(hc_a), 32'd0);
    check("lit_rst_stall", 0, 32'(sc_a), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; #1;
    check("lit_rst_resume", 0, 32'(hc_a), 32'd1);
    cyc(1);
    check("lit_rst_stall1", 0, 32'(sc_a), 32'd1);

    idle(); cyc(2);
    run_cmp = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
